mtm_alu_core_pipe: RTL and testbench

Parametrised, pipelined successor to the single-stage ALU core: same CTL encoding, flags and 3-bit CRC response, but with a generic operand width, a valid/ready handshake on both sides with full backpressure, correct signed-overflow flags and an error-packet counter. It sits between the packet deserializer and the response serializer. It accepts one operation per cycle and returns one response per operation, in order.

---
 rtl/mtm_alu_core_pipe.sv | 149 ++++++++++++++
 tb/tb_mtm_alu_core_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_core_pipe.sv
// Pipelined MTM ALU core: AND/OR/ADD/SUB with C/V/Z/N flags, CRC3 and error packets; MTM_ALU_EXT_OPS_EN adds XOR/SLT.
// Latency: 2 cycles from acceptance to response, one operation per cycle, responses in order.
// Backpressure: out_ready low freezes S2, then S1; in_ready drops only when both stages hold data.
module mtm_alu_core_pipe #(
  parameter int DATA_W   = 32,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic [7:0]          CTL_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   C,
  output logic [7:0]          CTL_out,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int MSB = DATA_W - 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
`ifdef MTM_ALU_EXT_OPS_EN
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b110;
`endif

  localparam logic [7:0] ERR_DATA = 8'hA5;
  localparam logic [7:0] ERR_CRC  = 8'hC9;
  localparam logic [7:0] ERR_OP   = 8'h93;

  typedef struct packed {
    logic              err;
    logic [7:0]        err_code;
    logic [DATA_W-1:0] res;
    logic              carry;
    logic              ovf;
    logic              zero;
    logic              neg;
  } s1_t;

  s1_t             s1_d;
  s1_t             s1_q;
  logic            s1_valid;
  logic            s1_en;
  logic            s2_en;
  logic [2:0]      op;
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic [2:0]      s2_crc;

  // The deserializer already checked the packet CRC; only the error code reports it.
  logic unused_crc_nibble;
  assign unused_crc_nibble = ^CTL_in[3:0];

  assign op   = CTL_in[6:4];
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    s1_d = '0;
    if (CTL_in[7]) begin
      s1_d.err      = 1'b1;
      s1_d.err_code = (CTL_in == ERR_DATA || CTL_in == ERR_CRC) ? CTL_in : ERR_OP;
    end else begin
      case (op)
        OP_AND: s1_d.res = A & B;
        OP_OR:  s1_d.res = A | B;
        OP_ADD: begin
          s1_d.res   = sum[MSB:0];
          s1_d.carry = sum[DATA_W];
          s1_d.ovf   = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
        end
        OP_SUB: begin
          // Extended subtraction leaves the borrow (A < B unsigned) in the top bit.
          s1_d.res   = diff[MSB:0];
          s1_d.carry = diff[DATA_W];
          s1_d.ovf   = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
        end
`ifdef MTM_ALU_EXT_OPS_EN
        OP_XOR: s1_d.res = A ^ B;
        OP_SLT: s1_d.res = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
`endif
        default: begin
          s1_d.err      = 1'b1;
          s1_d.err_code = ERR_OP;
        end
      endcase
    end
    s1_d.zero = (s1_d.res == '0);
    s1_d.neg  = s1_d.res[MSB];
  end

  // Serial x^3+x+1 LFSR unrolled over the message, MSB first, zero seed.
  function automatic logic [2:0] crc3(input logic [DATA_W+4:0] msg);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = DATA_W + 4; i >= 0; i--) begin
      fb = c[2] ^ msg[i];
      c  = {c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  assign s2_crc = crc3({s1_q.res, 1'b0, s1_q.carry, s1_q.ovf, s1_q.zero, s1_q.neg});

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // err_cnt counts when the error response enters S2, independent of when it leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      C         <= '0;
      CTL_out   <= 8'h00;
      err_cnt   <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        if (s1_q.err) begin
          C       <= '0;
          CTL_out <= s1_q.err_code;
          if (err_cnt != '1) err_cnt <= err_cnt + ERRCNT_W'(1);
        end else begin
          C       <= s1_q.res;
          CTL_out <= {1'b0, s1_q.carry, s1_q.ovf, s1_q.zero, s1_q.neg, s2_crc};
        end
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_core_pipe.sv
// Bench for mtm_alu_core_pipe: 32-bit instance checked through a scoreboard, 8-bit instance checked directly.
module tb_mtm_alu_core_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [7:0]  CTL_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] C;
  logic [7:0]  CTL_out;
  logic [15:0] err_cnt;

  logic        iv8 = 1'b0;
  logic        ir8;
  logic        ov8;
  logic        or8 = 1'b1;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [7:0]  ctl8 = '0;
  logic [7:0]  c8;
  logic [7:0]  co8;
  logic [1:0]  ec8;

  int n_chk = 0;
  int n_fail = 0;
  int n_resp = 0;
  int exp_err = 0;
  logic [40:0] exp_q[$];
  logic [40:0] mon_e;
  logic        rnd_done = 1'b0;

  mtm_alu_core_pipe #(.DATA_W(32), .ERRCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .CTL_in(CTL_in), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .CTL_out(CTL_out), .err_cnt(err_cnt));

  mtm_alu_core_pipe #(.DATA_W(8), .ERRCNT_W(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .CTL_in(ctl8), .out_valid(ov8), .out_ready(or8),
    .C(c8), .CTL_out(co8), .err_cnt(ec8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {err, C[31:0], CTL_out}; CRC as remainder of msg*x^3 mod 1011.
  function automatic logic [40:0] model(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                        input logic [7:0] ctl);
    logic [31:0] mask, a, b, r;
    logic        cy, ov, z, n, ok;
    logic [63:0] m, rem;
    longint      sa, sb;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    a = ai & mask;
    b = bi & mask;
    r = '0; cy = 1'b0; ov = 1'b0; ok = 1'b1;
    if (ctl[7]) return {1'b1, 32'h0, (ctl == 8'hA5 || ctl == 8'hC9) ? ctl : 8'h93};
    case (ctl[6:4])
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b100: begin
        m  = 64'(a) + 64'(b);
        r  = m[31:0] & mask;
        cy = m[w];
        ov = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'b101: begin
        r  = (a - b) & mask;
        cy = (a < b);
        ov = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
`ifdef MTM_ALU_EXT_OPS_EN
      3'b010: r = a ^ b;
      3'b110: begin
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        r  = (sa < sb) ? 32'd1 : 32'd0;
      end
`endif
      default: ok = 1'b0;
    endcase
    if (!ok) return {1'b1, 32'h0, 8'h93};
    z = (r == 32'h0);
    n = r[w-1];
    m = (64'(r) << 5) | 64'({cy, ov, z, n});
    rem = m << 3;
    for (int i = w + 7; i >= 3; i--)
      if (rem[i]) rem = rem ^ (64'hB << (i - 3));
    return {1'b0, r, 1'b0, cy, ov, z, n, rem[2:0]};
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_err = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_resp++;
        chk("sb_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("sb_C", 64'(C), 64'(mon_e[39:8]));
          chk("sb_CTL_out", 64'(CTL_out), 64'(mon_e[7:0]));
        end
      end
      if (in_valid && in_ready) begin
        mon_e = model(32, A, B, CTL_in);
        exp_q.push_back(mon_e);
        if (mon_e[40]) exp_err++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl);
    logic acc;
    acc = 1'b0;
    A = a; B = b; CTL_in = ctl; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    chk("accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_out(output logic [31:0] c, output logic [7:0] t);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
    c = C;
    t = CTL_out;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic [31:0] ta[8] = '{32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678,
                         32'h0, 32'h7FFF_FFFF, 32'hAAAA_5555, 32'h3};
  logic [31:0] tb[8] = '{32'h2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8765_4321,
                         32'h0, 32'hFFFF_FFFF, 32'h5555_AAAA, 32'h5};
  logic [7:0]  tc[8] = '{8'h40, 8'h40, 8'h50, 8'h57, 8'h00, 8'h10, 8'h1F, 8'h50};
  logic [7:0]  t4[4] = '{8'hA5, 8'hC9, 8'h80, 8'h3A};
  logic [7:0]  t4e[4] = '{8'hA5, 8'hC9, 8'h93, 8'h93};

  initial begin
    logic [31:0] c;
    logic [7:0]  t;
    logic [31:0] hold_c;
    logic [7:0]  hold_t;
    logic [7:0]  rc;
    int          base;
    int          r;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_C", 64'(C), 64'd0);
    chk("rst_CTL_out", 64'(CTL_out), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_in_ready8", 64'(ir8), 64'd1);

    // AND with exact 2-cycle latency
    @(posedge clk); #1;
    A = 32'h0F0F_0F0F; B = 32'hF0F0_F0F0; CTL_in = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("and_C", 64'(C), 64'd0);
    chk("and_CTL", 64'(CTL_out), 64'h16);
    @(posedge clk); #1;

    // ADD carry-out and signed overflow
    send_op(32'hFFFF_FFFF, 32'h1, 8'h40);
    wait_out(c, t);
    chk("add_carry_C", 64'(c), 64'd0);
    chk("add_carry_CTL", 64'(t), 64'h53);
    send_op(32'h7FFF_FFFF, 32'h1, 8'h40);
    wait_out(c, t);
    chk("add_ovf_C", 64'(c), 64'h8000_0000);
    chk("add_ovf_CVZN", 64'(t[6:3]), 64'b0101);

    // Back-to-back stream with a 5-cycle output stall
    base = n_resp;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        fork
          begin
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            hold_c = C;
            hold_t = CTL_out;
            @(posedge clk);
            @(negedge clk);
            chk("stall_hold_C", 64'(C), 64'(hold_c));
            chk("stall_hold_CTL", 64'(CTL_out), 64'(hold_t));
            @(posedge clk); #1;
            out_ready = 1'b1;
          end
        join_none
      end
      send_op(ta[i], tb[i], tc[i]);
    end
    drain();
    chk("stream_count", 64'(n_resp - base), 64'd8);

    // Error packets
    for (int i = 0; i < 4; i++) begin
      send_op(32'hDEAD_BEEF, 32'h1234_5678, t4[i]);
      wait_out(c, t);
      chk("err_CTL", 64'(t), 64'(t4e[i]));
      chk("err_C", 64'(c), 64'd0);
    end
    chk("err_cnt_4", 64'(err_cnt), 64'd4);

    // Random ops under random backpressure
    fork
      begin
        repeat (80) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        rnd_done = 1'b1;
      end
    join_none
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 8) rc = ($urandom_range(0, 1) != 0) ? 8'hA5 : 8'hC9;
      else if (r == 9) rc = 8'h80 | 8'($urandom_range(0, 127));
      else rc = {1'b0, 3'(r), 4'($urandom_range(0, 15))};
      send_op($urandom, $urandom, rc);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    for (int k = 0; k < 200 && !rnd_done; k++) @(posedge clk);
    #1;
    drain();
    chk("err_cnt_model", 64'(err_cnt), 64'(exp_err));

    // Asynchronous reset with two operations in flight
    send_op(32'h11, 32'h22, 8'h40);
    A = 32'h0; B = 32'h0; CTL_in = 8'hA5; in_valid = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_err_cnt", 64'(err_cnt), 64'd0);
    chk("arst_CTL_out", 64'(CTL_out), 64'd0);
    #9 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    base = n_resp;
    send_op(32'h5, 32'h3, 8'h50);
    wait_out(c, t);
    chk("post_rst_C", 64'(c), 64'd2);
    chk("post_rst_count", 64'(n_resp - base), 64'd1);
    chk("post_rst_err_cnt", 64'(err_cnt), 64'd0);

    // 8-bit instance: SUB borrow, SLT, counter saturation
    a8 = 8'h00; b8 = 8'h01; ctl8 = 8'h50; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(negedge clk);
    chk("w8_not_early", 64'(ov8), 64'd0);
    @(negedge clk);
    chk("w8_valid", 64'(ov8), 64'd1);
    chk("w8_sub_C", 64'(c8), 64'hFF);
    chk("w8_sub_CVN", 64'({co8[6], co8[5], co8[3]}), 64'b101);
    mon_e = model(8, 32'h0, 32'h1, 8'h50);
    chk("w8_sub_CTL", 64'(co8), 64'(mon_e[7:0]));
    @(posedge clk); #1;
`ifdef MTM_ALU_EXT_OPS_EN
    a8 = 8'h80; b8 = 8'h01; ctl8 = 8'h60; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("w8_slt_C", 64'(c8), 64'd1);
    @(posedge clk); #1;
`endif
    ctl8 = 8'h80; iv8 = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    iv8 = 1'b0;
    repeat (3) begin @(posedge clk); end
    #1;
    chk("w8_err_sat", 64'(ec8), 64'd3);
    chk("w8_err_CTL", 64'(co8), 64'h93);
    chk("w8_err_C", 64'(c8), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
